sm_addsub_unit: RTL and testbench

//  Parametrised sign-magnitude adder/subtractor with a 2-stage pipeline and valid/ready handshake.

---
 rtl/sm_arith_pkg.sv | 24 ++
 rtl/sm_mag_cmp.sv | 12 +
 rtl/sm_addsub_unit.sv | 132 +++++++++++++
 tb/tb_sm_addsub_unit.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_arith_pkg.sv
// Shared types and helpers for the sign-magnitude add/subtract unit.
// Operand layout: [SM_SIGN_POS] = sign (1 = negative), low SM_MAG_W bits = magnitude.
package sm_arith_pkg;

    localparam int   SM_MAG_W    = 7;
    localparam int   SM_SIGN_POS = SM_MAG_W;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic                sign_a;
        logic                sign_b_eff;
        logic [SM_MAG_W-1:0] mag_a;
        logic [SM_MAG_W-1:0] mag_b;
        logic                a_ge_b;
    } sm_s1_t;

    // Sign of a sign-magnitude value with -0 folded onto +0.
    function automatic logic sm_sign_of(input logic [SM_MAG_W:0] v);
        return v[SM_SIGN_POS] & (|v[SM_SIGN_POS-1:0]);
    endfunction

endpackage

// File: rtl/sm_mag_cmp.sv
// Combinational unsigned magnitude comparator: o_a_ge_b = (i_mag_a >= i_mag_b).
module sm_mag_cmp #(
    parameter int W = 7
) (
    input  logic [W-1:0] i_mag_a,
    input  logic [W-1:0] i_mag_b,
    output logic         o_a_ge_b
);

    assign o_a_ge_b = (i_mag_a >= i_mag_b);

endmodule

// File: rtl/sm_addsub_unit.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready on both sides.
// Build option SM_ADDSUB_SAT_EN: saturate the magnitude on overflow instead of wrapping.
module sm_addsub_unit
    import sm_arith_pkg::*;
#(
    parameter int MAG_W = SM_MAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [MAG_W:0]   in_a,
    input  logic [MAG_W:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W:0]   out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
);

    // Handshake: a beat moves on a side when valid && ready are both high at
    // the rising edge; valid never waits on ready, and data is held while
    // valid is high and ready is low.

    logic             r_s1_valid;
    sm_s1_t           r_s1;
    logic             r_s2_valid;
    logic [MAG_W:0]   r_out_result;
    logic             r_out_zero;
    logic             r_out_neg;
    logic             r_out_ovf;

    logic             w_s2_load;
    logic             w_s1_free;
    logic             w_a_ge_b;
    sm_s1_t           w_s1_next;
    logic [MAG_W:0]   w_sum;
    logic             w_same;
    logic [MAG_W-1:0] w_mag;
    logic             w_sign;
    logic             w_ovf;
    logic             w_zero;
    logic             w_neg;

    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign w_s1_free = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_free;

    sm_mag_cmp #(
        .W (MAG_W)
    ) u_mag_cmp (
        .i_mag_a  (in_a[MAG_W-1:0]),
        .i_mag_b  (in_b[MAG_W-1:0]),
        .o_a_ge_b (w_a_ge_b)
    );

    // Subtraction is addition with B's sign flipped; -0 inputs become +0.
    always_comb begin
        w_s1_next            = '0;
        w_s1_next.sign_a     = sm_sign_of(in_a);
        w_s1_next.sign_b_eff = sm_sign_of({in_b[MAG_W] ^ (in_op == OP_SUB), in_b[MAG_W-1:0]});
        w_s1_next.mag_a      = in_a[MAG_W-1:0];
        w_s1_next.mag_b      = in_b[MAG_W-1:0];
        w_s1_next.a_ge_b     = w_a_ge_b;
    end

    assign w_sum  = {1'b0, r_s1.mag_a} + {1'b0, r_s1.mag_b};
    assign w_same = (r_s1.sign_a == r_s1.sign_b_eff);

    always_comb begin
        w_mag  = '0;
        w_sign = 1'b0;
        w_ovf  = 1'b0;
        if (w_same) begin
            w_sign = r_s1.sign_a;
            w_ovf  = w_sum[MAG_W];
            w_mag  = w_sum[MAG_W-1:0];
`ifdef SM_ADDSUB_SAT_EN
            if (w_ovf) begin
                w_mag = '1;
            end
`endif
        end else if (r_s1.a_ge_b) begin
            w_sign = r_s1.sign_a;
            w_mag  = r_s1.mag_a - r_s1.mag_b;
        end else begin
            w_sign = r_s1.sign_b_eff;
            w_mag  = r_s1.mag_b - r_s1.mag_a;
        end
    end

    // A zero magnitude is always reported as +0, even after a wrapping overflow.
    assign w_zero = (w_mag == '0);
    assign w_neg  = w_sign && !w_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1         <= '0;
            r_s2_valid   <= 1'b0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_neg    <= 1'b0;
            r_out_ovf    <= 1'b0;
        end else begin
            if (w_s1_free) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1 <= w_s1_next;
                end
            end
            if (w_s2_load) begin
                r_s2_valid   <= 1'b1;
                r_out_result <= {w_neg, w_mag};
                r_out_zero   <= w_zero;
                r_out_neg    <= w_neg;
                r_out_ovf    <= w_ovf;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_neg    = r_out_neg;
    assign out_ovf    = r_out_ovf;

endmodule

// File: tb/tb_sm_addsub_unit.sv
// Scoreboard bench for sm_addsub_unit: stimulus pushes expected words, a monitor pops on each output beat.
// Expected word layout: {ovf, neg, zero, result}.
module tb_sm_addsub_unit;
    import sm_arith_pkg::*;

    localparam int MAG_W = 7;
    localparam int W     = MAG_W + 1;
    localparam int EW    = W + 3;
    localparam int MAXM  = (1 << MAG_W) - 1;
`ifdef SM_ADDSUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_op;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_result;
    logic           out_zero;
    logic           out_neg;
    logic           out_ovf;

    logic [EW-1:0]  exp_q[$];
    int             pop_cycles[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    int             cyc      = 0;
    int             stall_cnt = 0;

    sm_addsub_unit #(.MAG_W(MAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        int va, vb, r, m;
        logic s, ovf, z;
        logic [W-1:0] res;
        va = a[MAG_W] ? -int'(a[MAG_W-1:0]) : int'(a[MAG_W-1:0]);
        vb = b[MAG_W] ? -int'(b[MAG_W-1:0]) : int'(b[MAG_W-1:0]);
        r  = (op == OP_SUB) ? va - vb : va + vb;
        s  = (r < 0);
        m  = s ? -r : r;
        ovf = (m > MAXM);
        if (ovf) m = SAT ? MAXM : (m % (MAXM + 1));
        z = (m == 0);
        if (z) s = 1'b0;
        res = {s, m[MAG_W-1:0]};
        return {ovf, s, z, res};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [EW-1:0] exp);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            stall_cnt++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic op;
        logic [W-1:0] a, b;
        op = 1'($urandom_range(0, 1));
        a  = W'($urandom_range(0, 255));
        b  = W'($urandom_range(0, 255));
        case ($urandom_range(0, 7))
            0: a[MAG_W-1:0] = '0;
            1: b[MAG_W-1:0] = '0;
            2: a[MAG_W-1:0] = '1;
            3: b[MAG_W-1:0] = b[MAG_W-1:0] == '0 ? '1 : a[MAG_W-1:0];
            default: ;
        endcase
        send_beat(op, a, b, model(op, a, b));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results never appeared", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] cur, held, exp;
        logic          prev_stall;
        prev_stall = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                cur = {out_ovf, out_neg, out_zero, out_result};
                if (prev_stall) check("stall_hold", 32'(cur), 32'(held));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got 0x%0h with nothing expected", cur);
                    end else begin
                        exp = exp_q.pop_front();
                        check("result", 32'(cur), 32'(exp));
                        pop_cycles.push_back(cyc);
                    end
                end
                prev_stall = !out_ready;
                held       = cur;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int s0, n0, acc, done;
        logic [W-1:0] a5[5];
        logic [W-1:0] b5[5];
        logic         op5[5];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = OP_ADD;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_flags", 32'({out_ovf, out_neg, out_zero, out_result}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);

        // Directed: mixed signs, latency of two cycles
        send_beat(OP_ADD, 8'h05, 8'h8C, {1'b0, 1'b1, 1'b0, 8'h87});
        check("latency_early", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check("latency_2cyc", 32'(out_valid), 1);
        wait_drain();

        // Directed: zero results and -0 handling
        send_beat(OP_SUB, 8'h03, 8'h03, {1'b0, 1'b0, 1'b1, 8'h00});
        send_beat(OP_ADD, 8'h80, 8'h80, {1'b0, 1'b0, 1'b1, 8'h00});
        send_beat(OP_SUB, 8'h85, 8'h80, {1'b0, 1'b1, 1'b0, 8'h85});
        send_beat(OP_SUB, 8'h05, 8'h07, {1'b0, 1'b1, 1'b0, 8'h82});
        // Directed: overflow, wrap or saturate
        send_beat(OP_ADD, 8'h64, 8'h32, {1'b1, 1'b0, 1'b0, SAT ? 8'h7F : 8'h16});
        send_beat(OP_SUB, 8'hE4, 8'h32, {1'b1, 1'b1, 1'b0, SAT ? 8'hFF : 8'h96});
        send_beat(OP_ADD, 8'h7F, 8'h01, SAT ? {1'b1, 1'b0, 1'b0, 8'h7F} : {1'b1, 1'b0, 1'b1, 8'h00});
        send_beat(OP_ADD, 8'h7F, 8'h00, {1'b0, 1'b0, 1'b0, 8'h7F});
        wait_drain();

        // Back-to-back burst of 8 with the consumer always ready
        s0 = stall_cnt;
        n0 = pop_cycles.size();
        for (int i = 0; i < 8; i++) send_rand();
        wait_drain();
        check("burst_no_stall", 32'(stall_cnt - s0), 0);
        check("burst_count", 32'(pop_cycles.size() - n0), 8);
        if (pop_cycles.size() - n0 == 8) check("burst_consecutive", 32'(pop_cycles[n0 + 7] - pop_cycles[n0]), 7);

        // Backpressure: consumer stalls for five cycles with input always offered
        for (int i = 0; i < 5; i++) begin
            op5[i] = 1'($urandom_range(0, 1));
            a5[i]  = W'($urandom_range(0, 255));
            b5[i]  = W'($urandom_range(0, 255));
        end
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        in_op     = op5[0];
        in_a      = a5[0];
        in_b      = b5[0];
        repeat (5) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(op5[acc], a5[acc], b5[acc]));
                acc++;
            end
            @(posedge clk);
            #1;
            in_op = op5[acc];
            in_a  = a5[acc];
            in_b  = b5[acc];
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc), 2);
        check("bp_in_ready_low", 32'(in_ready), 0);
        out_ready = 1'b1;
        for (int i = acc; i < 5; i++) send_beat(op5[i], a5[i], b5[i], model(op5[i], a5[i], b5[i]));
        wait_drain();

        // Randomized traffic with random consumer backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) send_rand();
                done = 1;
            end
            begin
                while (done == 0) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send_beat(OP_ADD, 8'h11, 8'h22, model(OP_ADD, 8'h11, 8'h22));
        send_beat(OP_SUB, 8'h33, 8'h44, model(OP_SUB, 8'h33, 8'h44));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_result", 32'(out_result), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        n0 = pop_cycles.size();
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_no_stale", 32'(out_valid), 0);
        check("post_rst_no_pops", 32'(pop_cycles.size() - n0), 0);

        // Pipeline recovers after reset
        send_beat(OP_ADD, 8'h8A, 8'h0A, {1'b0, 1'b0, 1'b1, 8'h00});
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
